// File: rtl/pc_gen_bpred.sv
// rtl/pc_gen_bpred.sv - fetch PC generator with direct-mapped BTB and 2-bit counters
// Optional event counters are compiled in with PC_GEN_BPRED_STATS_EN.
module pc_gen_bpred #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter int unsigned     IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall_f,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target
`ifdef PC_GEN_BPRED_STATS_EN
  ,
  output logic [31:0]     o_stat_pred_cnt,
  output logic [31:0]     o_stat_redirect_cnt
`endif
);

  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [XLEN-1:0]  pc_plus4;

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic [XLEN-1:0]  wr_target;

  logic [XLEN-1:0]  next_pc;
  logic             unused_low_bits;

  assign rd_idx   = o_pc[IDX_W+1:2];
  assign rd_tag   = o_pc[XLEN-1:IDX_W+2];
  assign rd_hit   = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pc_plus4 = o_pc + XLEN'(4);

  assign o_pred_taken  = rd_hit && btb_ctr[rd_idx][1];
  assign o_pred_target = o_pred_taken ? btb_target[rd_idx] : pc_plus4;

  assign wr_idx    = i_upd_pc[IDX_W+1:2];
  assign wr_tag    = i_upd_pc[XLEN-1:IDX_W+2];
  assign wr_hit    = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign wr_target = {i_upd_target[XLEN-1:2], 2'b00};

  // Instruction addresses are word aligned; the low bits of these inputs are ignored.
  assign unused_low_bits = ^{i_redirect_pc[1:0], i_upd_pc[1:0], i_upd_target[1:0]};

  always_comb begin
    next_pc = o_pred_target;
    if (i_redirect) begin
      next_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
    end else if (i_stall_f) begin
      next_pc = o_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc <= RESET_PC;
    end else begin
      o_pc <= next_pc;
    end
  end

  // Valid bits and counters carry the reset state; tag/target are only meaningful once valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b01;
      end
    end else if (i_upd_en) begin
      if (wr_hit) begin
        if (i_upd_taken) begin
          if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'b01;
        end else begin
          if (btb_ctr[wr_idx] != 2'b00) btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'b01;
        end
      end else if (i_upd_taken) begin
        btb_valid[wr_idx] <= 1'b1;
        btb_ctr[wr_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_upd_en && i_upd_taken) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= wr_target;
    end
  end

`ifdef PC_GEN_BPRED_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_pred_cnt     <= '0;
      o_stat_redirect_cnt <= '0;
    end else begin
      if (!i_stall_f && o_pred_taken) o_stat_pred_cnt <= o_stat_pred_cnt + 32'd1;
      if (i_redirect) o_stat_redirect_cnt <= o_stat_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen_bpred.sv
// tb/tb_pc_gen_bpred.sv - directed and randomized bench for pc_gen_bpred
// Reference model: per-entry arrays indexed by arithmetic on the PC.
module tb_pc_gen_bpred;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
`ifdef PC_GEN_BPRED_STATS_EN
  logic [31:0] stat_pred_cnt;
  logic [31:0] stat_redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  pc_gen_bpred #(.XLEN(32), .RESET_PC(32'h0), .BTB_ENTRIES(N)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall_f    (stall_f),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_upd_en     (upd_en),
    .i_upd_pc     (upd_pc),
    .i_upd_target (upd_target),
    .i_upd_taken  (upd_taken),
    .o_pc         (pc),
    .o_pred_taken (pred_taken),
    .o_pred_target(pred_target)
`ifdef PC_GEN_BPRED_STATS_EN
    ,
    .o_stat_pred_cnt    (stat_pred_cnt),
    .o_stat_redirect_cnt(stat_redirect_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return int'(a / (4 * N));
  endfunction

  function automatic bit model_taken(input logic [31:0] a);
    int i = idx_of(a);
    return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] a);
    return model_taken(a) ? m_tgt[idx_of(a)] : a + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_pc = 32'h0;
  endtask

  task automatic model_train(input logic [31:0] a, input logic [31:0] t, input bit tk);
    int i = idx_of(a);
    bit hit = m_valid[i] && (m_tag[i] == tag_of(a));
    if (hit) begin
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_tgt[i] = t & ~32'd3;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(a);
      m_tgt[i]   = t & ~32'd3;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic idle_inputs();
    stall_f = 0; redirect = 0; redirect_pc = 0;
    upd_en = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
  endtask

  // Check outputs at the falling edge, then advance the model with the inputs seen at the rising edge.
  task automatic cycle();
    logic [31:0] nxt;
    @(negedge clk);
    check("pc", pc, m_pc);
    check("pred_taken", {31'd0, pred_taken}, {31'd0, model_taken(m_pc)});
    check("pred_target", pred_target, model_target(m_pc));
    @(posedge clk);
    if (redirect)     nxt = redirect_pc & ~32'd3;
    else if (stall_f) nxt = m_pc;
    else              nxt = model_target(m_pc);
    if (upd_en) model_train(upd_pc, upd_target, upd_taken);
    m_pc = nxt;
    #1;
    idle_inputs();
  endtask

  task automatic train_and_fetch(input logic [31:0] a, input logic [31:0] t, input bit tk,
                                 input logic [31:0] fetch);
    upd_en = 1; upd_pc = a; upd_target = t; upd_taken = tk;
    redirect = 1; redirect_pc = fetch;
    cycle();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_taken", {31'd0, pred_taken}, 32'd0);
    check("reset_target", pred_target, 32'h4);
`ifdef PC_GEN_BPRED_STATS_EN
    check("reset_stat_pred", stat_pred_cnt, 32'd0);
    check("reset_stat_redir", stat_redirect_cnt, 32'd0);
`endif
    rst_n = 1;

    repeat (3) cycle();
    check("seq_pc_c", pc, 32'hC);
    cycle();
    check("at_0x10", pc, 32'h10);

    for (int k = 0; k < 3; k++) begin
      stall_f = 1;
      cycle();
      check("stall_hold", pc, 32'h10);
    end
    stall_f = 1; redirect = 1; redirect_pc = 32'h203;
    cycle();
    check("redirect_over_stall", pc, 32'h200);

    train_and_fetch(32'h40, 32'h100, 1'b1, 32'h40);
    check("trained_taken", {31'd0, pred_taken}, 32'd1);
    check("trained_target", pred_target, 32'h100);
    cycle();
    check("follow_pred", pc, 32'h100);
    train_and_fetch(32'h40, 32'h100, 1'b0, 32'h40);
    check("weak_not_taken", {31'd0, pred_taken}, 32'd0);
    check("weak_target", pred_target, 32'h44);

    for (int k = 0; k < 6; k++) begin
      train_and_fetch(32'h48, 32'h180, (k < 4), 32'h48);
      check("sat_taken", {31'd0, pred_taken}, (k < 5) ? 32'd1 : 32'd0);
    end

    train_and_fetch(32'h40, 32'h100, 1'b1, 32'h80);
    check("alias_miss", {31'd0, pred_taken}, 32'd0);
    check("alias_target", pred_target, 32'h84);
    train_and_fetch(32'h80, 32'h300, 1'b0, 32'h40);
    check("alias_kept", {31'd0, pred_taken}, 32'd1);
    check("alias_kept_tgt", pred_target, 32'h100);

    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    cycle();
    check("wrap_zero", pc, 32'h0);

    redirect = 1; redirect_pc = 32'h40;
    cycle();
    check("pre_reset_hit", {31'd0, pred_taken}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("async_reset_pc", pc, 32'h0);
`ifdef PC_GEN_BPRED_STATS_EN
    check("async_stat_pred", stat_pred_cnt, 32'd0);
    check("async_stat_redir", stat_redirect_cnt, 32'd0);
`endif
    rst_n = 1;
    model_reset();
    redirect = 1; redirect_pc = 32'h40;
    cycle();
    check("post_reset_miss", {31'd0, pred_taken}, 32'd0);
    check("post_reset_tgt", pred_target, 32'h44);

    for (int k = 0; k < 600; k++) begin
      stall_f  = ($urandom_range(0, 7) == 0);
      redirect = ($urandom_range(0, 5) == 0);
      redirect_pc = {22'd0, 10'($urandom_range(0, 1023))};
      upd_en   = ($urandom_range(0, 2) == 0);
      upd_pc   = {22'd0, 10'($urandom_range(0, 1023))};
      if ($urandom_range(0, 1) == 0) upd_pc = m_pc;
      upd_target = {22'd0, 10'($urandom_range(0, 1023))};
      upd_taken  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
